// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/PAUSED/OVER control, speed-scaled movement strobe
// and reversal-safe direction arbitration for the snake datapath.
//
// state  | meaning
// IDLE   | datapath held in reset, waiting for btn_start
// PLAY   | moving: tick counter, direction and score live
// PAUSED | everything frozen until btn_pause/btn_start
// OVER   | collision seen, timed hold before returning to IDLE
module snake_game_ctrl #(
    parameter int DIV_W       = 24,
    parameter int BASE_DIV    = 10000000,
    parameter int STEP_DIV    = 250000,
    parameter int MIN_DIV     = 2500000,
    parameter int OVER_CYCLES = 200000000,
    parameter int SCORE_W     = 8
) (
    input  logic               CLK_100MHz,
    input  logic               Reset_n,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_up,
    input  logic               btn_right,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               gameOver,
    input  logic               apple_eaten,
    output logic [1:0]         dir,
    output logic               Go,
    output logic               game_reset,
    output logic               update_tick,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PLAY   = 2'b01,
        PAUSED = 2'b10,
        OVER   = 2'b11
    } gameState_t;

    localparam int OVER_W = $clog2(OVER_CYCLES + 1);

    localparam logic [DIV_W-1:0]   BASE_P    = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0]   STEP_P    = DIV_W'(STEP_DIV);
    localparam logic [DIV_W-1:0]   MIN_P     = DIV_W'(MIN_DIV);
    // Smallest period that can still take a full step without dropping under the floor
    localparam logic [DIV_W:0]     STEP_OK   = (DIV_W+1)'(MIN_DIV) + (DIV_W+1)'(STEP_DIV);
    localparam logic [OVER_W-1:0]  OVER_LAST = OVER_W'(OVER_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    gameState_t        gameState;
    logic [DIV_W-1:0]  period;
    logic [DIV_W-1:0]  tickCnt;
    logic [OVER_W-1:0] overCnt;
    logic [1:0]        pendingDir;
    logic [1:0]        btnDir;
    logic              btnAny;

    assign state      = gameState;
    assign game_reset = (gameState == IDLE);

    always_comb begin
        btnAny = btn_up | btn_right | btn_down | btn_left;
        btnDir = 2'b11;
        if (btn_up)
            btnDir = 2'b00;
        else if (btn_right)
            btnDir = 2'b01;
        else if (btn_down)
            btnDir = 2'b10;
    end

    always_ff @(posedge CLK_100MHz) begin
        if (!Reset_n) begin
            gameState   <= IDLE;
            dir         <= 2'b01;
            pendingDir  <= 2'b01;
            Go          <= 1'b0;
            update_tick <= 1'b0;
            score       <= '0;
            period      <= BASE_P;
            tickCnt     <= '0;
            overCnt     <= '0;
        end else begin
            Go          <= 1'b0;
            update_tick <= 1'b0;
            case (gameState)
                IDLE: begin
                    if (btn_start) begin
                        gameState  <= PLAY;
                        Go         <= 1'b1;
                        score      <= '0;
                        period     <= BASE_P;
                        dir        <= 2'b01;
                        pendingDir <= 2'b01;
                        tickCnt    <= '0;
                    end
                end
                PLAY: begin
                    // Reversal is judged against the committed direction only
                    if (btnAny && (btnDir != (dir ^ 2'b10)))
                        pendingDir <= btnDir;
                    if (apple_eaten) begin
                        if (score != SCORE_MAX)
                            score <= score + 1'b1;
                        period <= ({1'b0, period} >= STEP_OK) ? (period - STEP_P) : MIN_P;
                    end
                    if (gameOver) begin
                        gameState <= OVER;
                        overCnt   <= '0;
                    end else if (btn_pause) begin
                        gameState <= PAUSED;
                    end else if (tickCnt >= (period - 1'b1)) begin
                        // >= catches a count already past a freshly shortened period
                        tickCnt     <= '0;
                        update_tick <= 1'b1;
                        dir         <= pendingDir;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                PAUSED: begin
                    if (btn_pause || btn_start)
                        gameState <= PLAY;
                end
                OVER: begin
                    if (btn_start || (overCnt == OVER_LAST))
                        gameState <= IDLE;
                    else
                        overCnt <= overCnt + 1'b1;
                end
                default: gameState <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed and random stimulus for snake_game_ctrl, checked every cycle against a
// behavioural game model.
module tb_snake_game_ctrl;

    localparam int BASE  = 10;
    localparam int STEP  = 2;
    localparam int MINP  = 4;
    localparam int OVERC = 5;

    // Stimulus mask bits
    localparam int S = 1, P = 2, U = 4, R = 8, D = 16, L = 32, G = 64, A = 128, RST = 256;

    logic       CLK_100MHz = 1'b0;
    logic       Reset_n = 1'b0;
    logic       btn_start = 1'b0, btn_pause = 1'b0;
    logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       gameOver = 1'b0, apple_eaten = 1'b0;
    logic [1:0] dir, state;
    logic       Go, game_reset, update_tick;
    logic [7:0] score;

    always #5 CLK_100MHz = ~CLK_100MHz;

    snake_game_ctrl #(
        .DIV_W(24), .BASE_DIV(BASE), .STEP_DIV(STEP), .MIN_DIV(MINP),
        .OVER_CYCLES(OVERC), .SCORE_W(8)
    ) dut (
        .CLK_100MHz (CLK_100MHz),
        .Reset_n    (Reset_n),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .gameOver   (gameOver),
        .apple_eaten(apple_eaten),
        .dir        (dir),
        .Go         (Go),
        .game_reset (game_reset),
        .update_tick(update_tick),
        .state      (state),
        .score      (score)
    );

    int vectors = 0, miscompares = 0;
    // Model of the game: phase 0 idle, 1 play, 2 paused, 3 over
    int mState, mDir, mPend, mGo, mTick, mScore, mPeriod, mCnt, mOver;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int m);
        bit st, pa, up, rt, dn, lf, go, ap, any;
        int want, oldPend, oldPeriod;
        st = (m & S) != 0;  pa = (m & P) != 0;
        up = (m & U) != 0;  rt = (m & R) != 0;
        dn = (m & D) != 0;  lf = (m & L) != 0;
        go = (m & G) != 0;  ap = (m & A) != 0;
        Reset_n = ((m & RST) == 0);
        btn_start = st; btn_pause = pa;
        btn_up = up; btn_right = rt; btn_down = dn; btn_left = lf;
        gameOver = go; apple_eaten = ap;
        @(posedge CLK_100MHz);
        if ((m & RST) != 0) begin
            mState = 0; mDir = 1; mPend = 1; mGo = 0; mTick = 0;
            mScore = 0; mPeriod = BASE; mCnt = 0; mOver = 0;
        end else begin
            mGo = 0;
            mTick = 0;
            case (mState)
                0: if (st) begin
                    mState = 1; mGo = 1; mScore = 0; mPeriod = BASE;
                    mDir = 1; mPend = 1; mCnt = 0;
                end
                1: begin
                    oldPend = mPend;
                    oldPeriod = mPeriod;
                    any = up | rt | dn | lf;
                    want = up ? 0 : rt ? 1 : dn ? 2 : 3;
                    if (any && want != (mDir ^ 2)) mPend = want;
                    if (ap) begin
                        mScore = (mScore < 255) ? mScore + 1 : 255;
                        mPeriod = (mPeriod - STEP > MINP) ? mPeriod - STEP : MINP;
                    end
                    if (go) begin
                        mState = 3; mOver = 0;
                    end else if (pa) begin
                        mState = 2;
                    end else if (mCnt >= oldPeriod - 1) begin
                        mCnt = 0; mTick = 1; mDir = oldPend;
                    end else begin
                        mCnt++;
                    end
                end
                2: if (pa || st) mState = 1;
                default: if (st || mOver == OVERC - 1) mState = 0; else mOver++;
            endcase
        end
        #1;
        chk("state", {30'b0, state}, mState);
        chk("dir", {30'b0, dir}, mDir);
        chk("Go", {31'b0, Go}, mGo);
        chk("update_tick", {31'b0, update_tick}, mTick);
        chk("score", {24'b0, score}, mScore);
        chk("game_reset", {31'b0, game_reset}, (mState == 0) ? 1 : 0);
    endtask

    // Steps until update_tick is seen; first step uses firstMask. Bounded at 40.
    task automatic wait_tick(input int firstMask, output int gap);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            step((i == 0) ? firstMask : 0);
            gap++;
            if (update_tick === 1'b1) break;
        end
    endtask

    initial begin
        int gap, nt, m;

        // Reset and start
        step(RST);
        step(RST);
        chk("rst_state", {30'b0, state}, 0);
        chk("rst_dir", {30'b0, dir}, 1);
        chk("rst_game_reset", {31'b0, game_reset}, 1);
        step(0);
        step(0);
        step(S);
        chk("start_go", {31'b0, Go}, 1);
        chk("start_state", {30'b0, state}, 1);
        step(0);
        chk("go_one_cycle", {31'b0, Go}, 0);
        wait_tick(0, gap);  // the extra step above counts toward the first period
        chk("first_gap", gap, 9);
        wait_tick(0, gap); chk("gap_10a", gap, 10);
        wait_tick(0, gap); chk("gap_10b", gap, 10);

        // Direction arbitration
        step(L);
        wait_tick(0, gap); chk("left_rejected", {30'b0, dir}, 1);
        step(U); step(0); step(L);
        wait_tick(0, gap); chk("up_then_left", {30'b0, dir}, 0);
        step(R);
        wait_tick(0, gap); chk("turn_right", {30'b0, dir}, 1);
        step(U | D);
        wait_tick(0, gap); chk("up_beats_down", {30'b0, dir}, 0);

        // Speed-up and score saturation
        wait_tick(A, gap); chk("gap_8", gap, 8);
        wait_tick(A, gap); chk("gap_6", gap, 6);
        wait_tick(A, gap); chk("gap_4", gap, 4);
        wait_tick(A, gap); chk("gap_floor", gap, 4);
        chk("score_4", {24'b0, score}, 4);
        for (int i = 0; i < 300; i++) step(A);
        chk("score_sat", {24'b0, score}, 255);

        // OVER then start back to IDLE, start+pause in IDLE
        step(G);
        step(S);
        chk("over_start_idle", {30'b0, state}, 0);
        step(S | P);
        chk("start_beats_pause", {30'b0, state}, 1);

        // Pause mid-period
        for (int i = 0; i < 12 && mCnt != 5; i++) step(0);
        step(P);
        chk("paused", {30'b0, state}, 2);
        nt = 0;
        for (int i = 0; i < 50; i++) begin
            step(U);
            nt += int'(update_tick);
        end
        chk("pause_no_ticks", nt, 0);
        step(P);
        chk("resume_state", {30'b0, state}, 1);
        chk("resume_no_go", {31'b0, Go}, 0);
        wait_tick(0, gap); chk("resume_gap", gap, 5);

        // Collision together with an apple
        step(A); step(A);
        step(G | A);
        chk("over_state", {30'b0, state}, 3);
        chk("over_score", {24'b0, score}, 3);
        for (int i = 0; i < 4; i++) begin
            step(0);
            chk("over_hold", {30'b0, state}, 3);
        end
        step(0);
        chk("over_to_idle", {30'b0, state}, 0);
        chk("idle_game_reset", {31'b0, game_reset}, 1);
        chk("idle_score_held", {24'b0, score}, 3);
        step(A);
        chk("idle_apple_ignored", {24'b0, score}, 3);

        // Reset mid-game
        step(S);
        step(A); step(A); step(A);
        step(U);
        wait_tick(0, gap);
        chk("pre_rst_dir", {30'b0, dir}, 0);
        chk("pre_rst_score", {24'b0, score}, 3);
        step(RST | S);
        chk("midrst_state", {30'b0, state}, 0);
        chk("midrst_score", {24'b0, score}, 0);
        chk("midrst_dir", {30'b0, dir}, 1);
        chk("midrst_go", {31'b0, Go}, 0);
        chk("midrst_tick", {31'b0, update_tick}, 0);
        step(S);
        wait_tick(0, gap); chk("midrst_period", gap, 10);

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            m = 0;
            if ($urandom_range(0, 29) == 0)  m |= S;
            if ($urandom_range(0, 39) == 0)  m |= P;
            if ($urandom_range(0, 5) == 0)   m |= U;
            if ($urandom_range(0, 5) == 0)   m |= R;
            if ($urandom_range(0, 5) == 0)   m |= D;
            if ($urandom_range(0, 5) == 0)   m |= L;
            if ($urandom_range(0, 149) == 0) m |= G;
            if ($urandom_range(0, 11) == 0)  m |= A;
            if ($urandom_range(0, 499) == 0) m |= RST;
            step(m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Game sequencer for the snake datapath. It runs the IDLE/PLAY/PAUSED/OVER state machine and issues the datapath's Go and reset requests. It generates the movement update strobe, with a period that shortens as apples are eaten, and arbitrates the four direction buttons into a committed 2-bit direction, rejecting 180° reversals. It sits between the board button conditioners and the snake datapath, all on CLK_100MHz.

Parameters:
DIV_W, 24, width of the tick period counter and the period register
BASE_DIV, 10000000, update period in clock cycles at game start (10 Hz)
STEP_DIV, 250000, period reduction per apple eaten
MIN_DIV, 2500000, floor on the update period (must be >= 2)
OVER_CYCLES, 200000000, clock cycles spent in OVER before returning to IDLE
SCORE_W, 8, score width

Ports:
CLK_100MHz  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
btn_start  in  1  start request, single-cycle pulse, already debounced
btn_pause  in  1  pause/resume toggle, single-cycle pulse
btn_up  in  1  direction request pulse
btn_right  in  1  direction request pulse
btn_down  in  1  direction request pulse
btn_left  in  1  direction request pulse
gameOver  in  1  collision flag from the datapath (level)
apple_eaten  in  1  apple consumed, single-cycle pulse from the datapath
dir  out  2  committed direction: 00 up, 01 right, 10 down, 11 left
Go  out  1  one-cycle pulse that releases the datapath from pause
game_reset  out  1  datapath reset request (level)
update_tick  out  1  one-cycle movement strobe
state  out  2  00 IDLE, 01 PLAY, 10 PAUSED, 11 OVER
score  out  SCORE_W  apples eaten this game

Behaviour:
- One clock only, CLK_100MHz. Reset is synchronous, active-low (Reset_n) and overrides everything.
- Reset values: state=IDLE, dir=01, pending_dir=01, Go=0, game_reset=1, update_tick=0, score=0, period=BASE_DIV, tick_cnt=0, over_cnt=0.
- game_reset is combinational from state: 1 in IDLE, 0 otherwise.
- IDLE:
  - On btn_start, go to PLAY on the next edge.
  - Go=1 for exactly that one cycle (registered).
  - Same edge: score<=0, period<=BASE_DIV, dir<=01, pending_dir<=01, tick_cnt<=0.
- PLAY:
  - tick_cnt increments each cycle.
  - When tick_cnt==period-1: tick_cnt<=0, update_tick<=1 for one cycle, dir<=pending_dir on the same edge.
  - First update_tick occurs period cycles after entering PLAY.
- PLAY exits (priority gameOver > btn_pause):
  - gameOver=1 → OVER, over_cnt<=0.
  - btn_pause → PAUSED.
  - update_tick is never asserted on the exit edge.
- PAUSED:
  - tick_cnt, dir, pending_dir, score and period frozen; update_tick=0; direction buttons ignored.
  - btn_pause or btn_start → PLAY. No Go pulse. tick_cnt resumes from its held value.
- OVER:
  - over_cnt increments each cycle. At OVER_CYCLES-1, or on btn_start, go to IDLE.
  - score held; it stays visible through OVER and IDLE until the next start.
- Direction arbitration (PLAY only):
  - Same-cycle priority: up > right > down > left. Only the winning button is considered.
  - Candidate c is accepted into pending_dir unless c == dir ^ 2'b10 (reversal of the committed direction).
  - Reversal is checked against the committed dir, not pending_dir, so two turns within one tick cannot reverse the snake.
  - Last accepted press before the tick wins.
  - A press on the same edge as update_tick is not visible until the next tick: dir takes the old pending_dir.
- Score and speed (PLAY only):
  - On apple_eaten: score<=score+1, saturating at all-ones.
  - On apple_eaten: period<=max(period-STEP_DIV, MIN_DIV), computed in DIV_W bits without underflow.
  - The new period takes effect on the next comparison. If tick_cnt already >= the new period-1, the tick fires when tick_cnt == new period-1 wraps, i.e. compare with >= rather than ==.
  - apple_eaten is ignored in IDLE, PAUSED and OVER.
- Simultaneous gameOver and apple_eaten in PLAY: score increments and state goes to OVER.
- Simultaneous btn_start and btn_pause in IDLE: start wins.
- Reset_n low mid-game: returns to reset values at the next edge; a pending Go or update_tick is cancelled.

Test Plan:
(All scenarios use BASE_DIV=10, STEP_DIV=2, MIN_DIV=4, OVER_CYCLES=5.)
1. Release reset, pulse btn_start at cycle 3 → Go=1 in cycle 4 only, state=01, game_reset=0; update_tick pulses at cycles 14, 24, 34.
2. In PLAY with dir=01: pulse btn_left → dir stays 01 after the next tick. Pulse btn_up, then btn_left in a later cycle of the same tick period → dir=00 after the tick (left rejected). Pulse btn_up and btn_down in the same cycle → up chosen.
3. Pulse apple_eaten 4 times → score=4; tick spacing goes 10→8→6→4→4. 300 pulses → score saturates at 255.
4. Pulse btn_pause mid-period (tick_cnt=5) → state=10, no ticks for 50 cycles. btn_pause again → next tick 5 cycles later, no Go pulse.
5. Assert gameOver with apple_eaten in the same cycle → state=11, score+1. Return to IDLE after 5 cycles with game_reset=1 and score held. btn_start in OVER → IDLE next cycle.
6. Drop Reset_n for one cycle during PLAY with score=3, dir=00 → state=00, score=0, dir=01, period=10, Go=0, update_tick=0 on the following cycle.
